gpr_wb_arbiter: RTL and testbench
=================================

# gpr_wb_arbiter

Write-port scheduler for the 32x32 general-purpose register file in the 5-stage pipeline. It shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (multiply/divide). It buffers long-latency results until a free writeback slot exists. It also keeps a per-register pending scoreboard that stalls decode on RAW/WAW hazards against outstanding long-latency results.

## Interface
- BUF_DEPTH, 2: long-latency result buffer entries; power of 2, at least 2.
- STARVE_LIMIT, 4: cycles a buffered result may wait before decode is forced to stall.

Ports (clock and reset first):
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  pipeline writeback request; cannot be backpressured.
- wb_num  in  5  pipeline destination register.
- wb_data  in  32  pipeline writeback data.
- llu_issue  in  1  long-latency op issued this cycle.
- llu_issue_num  in  5  its destination register.
- llu_valid  in  1  long-latency result valid.
- llu_num  in  5  result destination.
- llu_data  in  32  result data.
- llu_ready  out  1  buffer can accept a result.
- rs, rt, rd_chk  in  5 each  decode-stage source/destination registers to check.
- stall  out  1  freeze decode and insert a bubble.
- reg_write  out  1  register-file write enable.
- num_write  out  5  register-file write index.
- data_write  out  32  register-file write data.
- busy_mask  out  32  scoreboard bits; bit 0 is always 0.

## Operation
- Write-port mux (combinational):
  - If wb_valid and wb_num != 0, drive wb_num/wb_data with reg_write=1 (pipeline grant).
  - Else if the buffer is non-empty, drive the head entry with reg_write=1 and pop it at the edge (buffer grant).
  - Else reg_write=0, num_write=0, data_write=0.
- Buffer: FIFO, BUF_DEPTH entries of {num, data}.
  - Push on llu_valid && llu_ready.
  - llu_ready = !full && !reset.
  - Simultaneous push and pop when full is not allowed, because llu_ready is low when full. When non-full, push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - A result with llu_num == 0 is accepted and popped but produces reg_write=0.
- Scoreboard: busy[n] is set at the edge when llu_issue && llu_issue_num == n && n != 0. It is cleared at the edge when a buffer pop writes register n. If set and clear hit the same n in the same cycle, set wins.
- Hazard stall: stall = busy[rs] | busy[rt] | busy[rd_chk] | starve. Register 0 is never busy.
- Starvation: an age counter increments each cycle the buffer is non-empty and no pop occurs. It clears on any pop or when the buffer is empty. starve = (age >= STARVE_LIMIT). The resulting decode stall drains bubbles into WB, which guarantees a pop.

## Timing
- Reset values: buffer empty, busy_mask=0, age=0, llu_ready=0, stall=0, reg_write=0, num_write=0, data_write=0.
- Reset mid-operation discards all buffered results and pending bits.
- Pipeline writeback latency is 0: the write lands in the register file at the same edge.
- Long-latency result latency is at least 1 cycle: the result is pushed at edge N, written at the earliest at edge N+1.
- The busy bit clears on the same edge that the register file is written. stall for that register drops in the following cycle, and the asynchronous read then returns the new value.
- The long-latency producer must hold llu_valid/llu_num/llu_data stable until it samples llu_ready=1 at an edge.

## Test plan
- Lone result, idle pipeline: push {num=5, data=0x1234} at edge 0 → edge 1: reg_write=1, num_write=5, data_write=0x1234; busy_mask[5] clears at edge 1.
- Conflict: wb_valid with wb_num=3, data 0xAA, in the same cycle the buffer holds {7, 0xBB} → the pipeline write goes first; {7, 0xBB} is written in the next cycle with wb_valid=0.
- RAW stall: llu_issue to r9, then decode rs=9 → stall=1 until the cycle after r9 is written; rs=0 never stalls.
- Backpressure: BUF_DEPTH=2, wb_valid=1 every cycle, three results offered → two accepted, llu_ready=0. starve and stall rise after 4 waiting cycles; the head drains on the first idle WB slot.
- Same-register set/clear: pop writes r4 in the same cycle a new llu_issue targets r4 → busy_mask[4] stays 1.
- Reset with 2 entries buffered → next cycle: llu_ready=1, busy_mask=0, no reg_write from stale entries.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Register-file write-port scheduler: pipeline writeback has priority, long-latency
// results wait in a small FIFO; a per-register scoreboard stalls decode on pending results.
module gpr_wb_arbiter #(
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_num,
  input  logic [31:0] wb_data,
  input  logic        llu_issue,
  input  logic [4:0]  llu_issue_num,
  input  logic        llu_valid,
  input  logic [4:0]  llu_num,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd_chk,
  output logic        stall,
  output logic        reg_write,
  output logic [4:0]  num_write,
  output logic [31:0] data_write,
  output logic [31:0] busy_mask
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      buf_num  [BUF_DEPTH];
  logic [31:0]     buf_data [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [AgeW-1:0] age_q, age_d;
  logic [31:0]     busy_q, busy_d;

  logic        empty, full, push, pop, pipe_grant, starve;
  logic [4:0]  head_num;
  logic [31:0] head_data;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(BUF_DEPTH));
  assign head_num   = buf_num[rd_ptr_q];
  assign head_data  = buf_data[rd_ptr_q];
  assign pipe_grant = wb_valid && (wb_num != 5'd0);
  assign llu_ready  = !full && !reset;
  assign push       = llu_valid && llu_ready;
  assign pop        = !reset && !pipe_grant && !empty;
  assign starve     = (age_q >= AgeW'(STARVE_LIMIT));
  assign busy_mask  = busy_q;
  assign stall      = !reset && (busy_q[rs] || busy_q[rt] || busy_q[rd_chk] || starve);

  always_comb begin
    reg_write  = 1'b0;
    num_write  = 5'd0;
    data_write = 32'd0;
    if (!reset) begin
      if (pipe_grant) begin
        reg_write  = 1'b1;
        num_write  = wb_num;
        data_write = wb_data;
      end else if (!empty) begin
        // A result for r0 is still popped, just never written.
        reg_write  = (head_num != 5'd0);
        num_write  = head_num;
        data_write = head_data;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (pop && head_num != 5'd0) busy_d[head_num] = 1'b0;
    // A new issue to the same register overrides the clear.
    if (llu_issue && llu_issue_num != 5'd0) busy_d[llu_issue_num] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    age_d = age_q;
    if (empty || pop) age_d = '0;
    else if (!starve) age_d = age_q + AgeW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      busy_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      age_q  <= age_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_num[wr_ptr_q]  <= llu_num;
      buf_data[wr_ptr_q] <= llu_data;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: inputs change 1ns after each rising edge,
// outputs are checked 2ns after the edge.
module tb_gpr_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        llu_issue;
  logic [4:0]  llu_issue_num;
  logic        llu_valid;
  logic [4:0]  llu_num;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic [4:0]  rs, rt, rd_chk;
  logic        stall;
  logic        reg_write;
  logic [4:0]  num_write;
  logic [31:0] data_write;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;

  gpr_wb_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_num        (wb_num),
    .wb_data       (wb_data),
    .llu_issue     (llu_issue),
    .llu_issue_num (llu_issue_num),
    .llu_valid     (llu_valid),
    .llu_num       (llu_num),
    .llu_data      (llu_data),
    .llu_ready     (llu_ready),
    .rs            (rs),
    .rt            (rt),
    .rd_chk        (rd_chk),
    .stall         (stall),
    .reg_write     (reg_write),
    .num_write     (num_write),
    .data_write    (data_write),
    .busy_mask     (busy_mask)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] n,
                          input logic [31:0] d);
    check_eq({tag, ".we"}, {31'd0, reg_write}, {31'd0, we});
    if (we) begin
      check_eq({tag, ".num"}, {27'd0, num_write}, {27'd0, n});
      check_eq({tag, ".data"}, data_write, d);
    end
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_num = '0; wb_data = '0;
    llu_issue = 1'b0; llu_issue_num = '0; llu_valid = 1'b0; llu_num = '0; llu_data = '0;
    rs = '0; rt = '0; rd_chk = '0;
    tick(); tick();
    settle();
    check_eq("rst.ready", {31'd0, llu_ready}, 32'd0);
    check_wr("rst.wr", 1'b0, 5'd0, 32'd0);

    // Release reset
    tick(); reset = 1'b0; settle();
    check_eq("idle.ready", {31'd0, llu_ready}, 32'd1);
    check_eq("idle.busy", busy_mask, 32'd0);
    check_eq("idle.stall", {31'd0, stall}, 32'd0);
    check_wr("idle.wr", 1'b0, 5'd0, 32'd0);

    // Lone result to r5
    llu_issue = 1'b1; llu_issue_num = 5'd5;
    tick(); llu_issue = 1'b0; llu_valid = 1'b1; llu_num = 5'd5; llu_data = 32'h1234; rs = 5'd5;
    settle();
    check_eq("lone.busy_set", busy_mask, 32'h0000_0020);
    check_eq("lone.stall", {31'd0, stall}, 32'd1);
    check_wr("lone.nowr", 1'b0, 5'd0, 32'd0);
    tick(); llu_valid = 1'b0; settle();
    check_wr("lone.wr", 1'b1, 5'd5, 32'h1234);
    check_eq("lone.busy_hold", busy_mask, 32'h0000_0020);
    tick(); settle();
    check_eq("lone.busy_clr", busy_mask, 32'd0);
    check_eq("lone.stall_clr", {31'd0, stall}, 32'd0);
    check_wr("lone.after", 1'b0, 5'd0, 32'd0);

    // RAW stall on r9; r0 never stalls
    rs = 5'd0; llu_issue = 1'b1; llu_issue_num = 5'd9;
    tick(); llu_issue = 1'b0; rs = 5'd9; settle();
    check_eq("raw.stall", {31'd0, stall}, 32'd1);
    rs = 5'd0; rt = 5'd0; rd_chk = 5'd0; settle();
    check_eq("raw.r0", {31'd0, stall}, 32'd0);
    rd_chk = 5'd9; settle();
    check_eq("raw.rd_chk", {31'd0, stall}, 32'd1);
    rd_chk = 5'd0; rt = 5'd9;
    llu_valid = 1'b1; llu_num = 5'd9; llu_data = 32'h9999;
    tick(); llu_valid = 1'b0; settle();
    check_wr("raw.wr", 1'b1, 5'd9, 32'h9999);
    check_eq("raw.stall_wr", {31'd0, stall}, 32'd1);
    tick(); settle();
    check_eq("raw.stall_drop", {31'd0, stall}, 32'd0);
    rt = 5'd0;

    // Pipeline beats a buffered result
    llu_valid = 1'b1; llu_num = 5'd7; llu_data = 32'hBB;
    tick(); llu_valid = 1'b0; wb_valid = 1'b1; wb_num = 5'd3; wb_data = 32'hAA; settle();
    check_wr("conf.pipe", 1'b1, 5'd3, 32'hAA);
    tick(); wb_valid = 1'b0; settle();
    check_wr("conf.buf", 1'b1, 5'd7, 32'hBB);
    tick(); settle();
    check_wr("conf.empty", 1'b0, 5'd0, 32'd0);

    // Backpressure and starvation with a saturated pipeline
    wb_valid = 1'b1; wb_num = 5'd1; wb_data = 32'h11;
    llu_valid = 1'b1; llu_num = 5'd10; llu_data = 32'hA0;
    tick(); llu_num = 5'd11; llu_data = 32'hA1; settle();
    check_eq("bp.ready1", {31'd0, llu_ready}, 32'd1);
    tick(); llu_num = 5'd12; llu_data = 32'hA2; settle();
    check_eq("bp.full", {31'd0, llu_ready}, 32'd0);
    check_wr("bp.pipe", 1'b1, 5'd1, 32'h11);
    tick(); settle();
    check_eq("bp.age2", {31'd0, stall}, 32'd0);
    tick(); settle();
    check_eq("bp.age3", {31'd0, stall}, 32'd0);
    tick(); settle();
    check_eq("bp.starve", {31'd0, stall}, 32'd1);
    check_eq("bp.full2", {31'd0, llu_ready}, 32'd0);
    wb_valid = 1'b0; settle();
    check_wr("bp.drain0", 1'b1, 5'd10, 32'hA0);
    tick(); settle();
    check_eq("bp.unstarve", {31'd0, stall}, 32'd0);
    check_eq("bp.ready2", {31'd0, llu_ready}, 32'd1);
    check_wr("bp.drain1", 1'b1, 5'd11, 32'hA1);
    tick(); llu_valid = 1'b0; settle();
    check_wr("bp.drain2", 1'b1, 5'd12, 32'hA2);
    tick(); settle();
    check_wr("bp.empty", 1'b0, 5'd0, 32'd0);

    // Result for r0 is popped without a write
    llu_valid = 1'b1; llu_num = 5'd0; llu_data = 32'hDEAD;
    tick(); llu_valid = 1'b0; settle();
    check_wr("r0.nowr", 1'b0, 5'd0, 32'd0);
    tick(); settle();
    check_wr("r0.gone", 1'b0, 5'd0, 32'd0);

    // Same-register set and clear: set wins
    llu_issue = 1'b1; llu_issue_num = 5'd4;
    tick(); llu_issue = 1'b0; llu_valid = 1'b1; llu_num = 5'd4; llu_data = 32'h44;
    tick(); llu_valid = 1'b0; llu_issue = 1'b1; llu_issue_num = 5'd4; settle();
    check_wr("same.wr", 1'b1, 5'd4, 32'h44);
    tick(); llu_issue = 1'b0; settle();
    check_eq("same.busy", busy_mask, 32'h0000_0010);

    // Reset with two entries buffered
    wb_valid = 1'b1; wb_num = 5'd2; wb_data = 32'h22;
    llu_issue = 1'b1; llu_issue_num = 5'd20;
    llu_valid = 1'b1; llu_num = 5'd20; llu_data = 32'hC0;
    tick(); llu_issue = 1'b0; llu_num = 5'd21; llu_data = 32'hC1;
    tick(); llu_valid = 1'b0; settle();
    check_eq("rst2.full", {31'd0, llu_ready}, 32'd0);
    check_eq("rst2.busy", busy_mask, 32'h0010_0010);
    reset = 1'b1;
    tick(); reset = 1'b0; wb_valid = 1'b0; settle();
    check_eq("rst2.ready", {31'd0, llu_ready}, 32'd1);
    check_eq("rst2.busy0", busy_mask, 32'd0);
    check_wr("rst2.nowr", 1'b0, 5'd0, 32'd0);
    check_eq("rst2.stall", {31'd0, stall}, 32'd0);
    tick(); settle();
    check_wr("rst2.nowr2", 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
